// File: rtl/remap_pkg.sv
// Shared constants and state encoding for the k-remap trigger generator.
// Table entries are packed {idx, frac}; the sample position is idx + frac/ONE.
package remap_pkg;

    localparam int WIDTH_DEF       = 16;
    localparam int FRACTIONBIT_DEF = 15;
    localparam int IDXW_DEF        = 12;
    localparam int AW_DEF          = 11;
    localparam int ENTRY_W         = IDXW_DEF + FRACTIONBIT_DEF;
    localparam int ONE             = 1 << FRACTIONBIT_DEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [IDXW_DEF-1:0] entry_idx(input logic [ENTRY_W-1:0] e);
        return e[ENTRY_W-1:FRACTIONBIT_DEF];
    endfunction

    function automatic logic [FRACTIONBIT_DEF-1:0] entry_frac(input logic [ENTRY_W-1:0] e);
        return e[FRACTIONBIT_DEF-1:0];
    endfunction

endpackage

// File: rtl/remap_table_ram.sv
// Simple dual-port table RAM: one write port, one registered read port.
// Contents are deliberately not reset so the host-loaded table survives rst.
module remap_table_ram #(
    parameter int AW = 11,
    parameter int DW = 27
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/remap_trig_gen.sv
// Emits each raw sample one stage late with an aligned trigger/fraction pair
// taken from the k-linearization table, one table entry per trigger.
module remap_trig_gen
    import remap_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int FRACTIONBIT = FRACTIONBIT_DEF,
    parameter int IDXW        = IDXW_DEF,
    parameter int AW          = AW_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [AW-1:0]               cfg_addr,
    input  logic [IDXW+FRACTIONBIT-1:0] cfg_wdata,
    input  logic [AW:0]                 cfg_len,
    input  logic                        cfg_clr_err,
    input  logic [WIDTH-1:0]            i_data,
    input  logic                        i_valid,
    input  logic                        i_sof,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_valid,
    output logic                        o_trigger,
    output logic [FRACTIONBIT:0]        o_fraction,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err
);

    localparam int EW = IDXW + FRACTIONBIT;
    localparam logic [IDXW-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]       in_data_reg;
    logic                   in_valid_reg;
    logic                   in_sof_reg;
    logic [AW:0]            in_len_reg;

    state_t                 state_reg, state_next;
    logic [IDXW-1:0]        count_reg, count_next;
    logic [AW:0]            ptr_reg, ptr_next;
    logic [AW:0]            len_reg, len_next;
    logic                   err_reg, err_next;

    logic [WIDTH-1:0]       out_data_reg, out_data_next;
    logic                   out_valid_reg, out_valid_next;
    logic                   out_trigger_reg, out_trigger_next;
    logic [FRACTIONBIT:0]   out_fraction_reg, out_fraction_next;
    logic                   out_done_reg, out_done_next;

    logic [EW-1:0]          entry_rd;
    logic [IDXW-1:0]        entry_idx_w;
    logic [FRACTIONBIT-1:0] entry_frac_w;
    logic [IDXW:0]          target;
    logic [IDXW-1:0]        sample_cnt;
    logic                   sof_acc, running, entries_left, cnt_sat;
    logic                   active, discard, hit, advance, last, wr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_data_reg  <= '0;
            in_valid_reg <= 1'b0;
            in_sof_reg   <= 1'b0;
            in_len_reg   <= '0;
        end else begin
            in_data_reg  <= i_data;
            in_valid_reg <= i_valid;
            in_sof_reg   <= i_sof;
            in_len_reg   <= cfg_len;
        end
    end

    // Read address follows ptr_next, so entry_rd always holds entry[ptr_reg]:
    // the following entry is ready the cycle after an advance, with no bubble.
    remap_table_ram #(
        .AW (AW),
        .DW (EW)
    ) u_table (
        .clk   (clk),
        .we    (cfg_we & wr_ok),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (ptr_next[AW-1:0]),
        .rdata (entry_rd)
    );

    assign entry_idx_w  = entry_rd[EW-1:FRACTIONBIT];
    assign entry_frac_w = entry_rd[FRACTIONBIT-1:0];
    assign target       = {1'b0, entry_idx_w} + (IDXW+1)'(1);
    assign sof_acc      = in_valid_reg & in_sof_reg;
    assign running      = (state_reg == ST_RUN);
    assign entries_left = (ptr_reg < len_reg);
    assign cnt_sat      = (count_reg == CNT_MAX);
    assign sample_cnt   = cnt_sat ? count_reg : count_reg + IDXW'(1);
    // Once the count saturates the table is frozen; leftovers are flagged at the next sof.
    assign active       = running & ~sof_acc & entries_left & ~cnt_sat;
    assign discard      = active & (target <= {1'b0, count_reg});
    assign hit          = active & ~discard & in_valid_reg & (target == {1'b0, sample_cnt});
    assign advance      = discard | hit;
    assign last         = advance & ((ptr_reg + (AW+1)'(1)) == len_reg);
    // A pending sof already counts as running so the table cannot change under it.
    assign wr_ok        = ~running & ~sof_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            ptr_reg   <= '0;
            len_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            ptr_reg   <= ptr_next;
            len_reg   <= len_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        ptr_next   = ptr_reg;
        len_next   = len_reg;
        if (sof_acc) begin
            state_next = ST_RUN;
            count_next = '0;
            ptr_next   = '0;
            len_next   = in_len_reg;
        end else if (running) begin
            if (in_valid_reg) begin
                count_next = sample_cnt;
            end
            if (advance) begin
                ptr_next = ptr_reg + (AW+1)'(1);
            end
            if (!entries_left) begin
                state_next = ST_IDLE;
            end
        end
    end

    always_comb begin
        err_next = discard
                 | (cfg_we & ~wr_ok)
                 | (sof_acc & running & entries_left)
                 | (err_reg & ~cfg_clr_err);
        out_data_next     = in_data_reg;
        out_valid_next    = in_valid_reg;
        out_trigger_next  = hit;
        out_fraction_next = hit ? {1'b0, entry_frac_w} : '0;
        out_done_next     = last | (sof_acc & (in_len_reg == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg     <= '0;
            out_valid_reg    <= 1'b0;
            out_trigger_reg  <= 1'b0;
            out_fraction_reg <= '0;
            out_done_reg     <= 1'b0;
        end else begin
            out_data_reg     <= out_data_next;
            out_valid_reg    <= out_valid_next;
            out_trigger_reg  <= out_trigger_next;
            out_fraction_reg <= out_fraction_next;
            out_done_reg     <= out_done_next;
        end
    end

    assign o_data     = out_data_reg;
    assign o_valid    = out_valid_reg;
    assign o_trigger  = out_trigger_reg;
    assign o_fraction = out_fraction_reg;
    assign o_busy     = running;
    assign o_done     = out_done_reg;
    assign o_err      = err_reg;

endmodule
